// File: rtl/cpu_pkg.sv
// Shared types for the data-memory port arbiter: default widths, FSM states and grant codes.
package cpu_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, GAP} arb_state_t;
  typedef enum logic [1:0] {G_NONE, G_RD0, G_RD1, G_WR} arb_grant_t;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Data-memory side of the arbiter: strobe/done handshake with separate read and write address buses.
interface dmem_port_arbiter_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              mem_in;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr_w;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;

  modport master (
    output mem_in, mem_adr, mem_we, mem_adr_w, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_in, mem_adr, mem_we, mem_adr_w, mem_wdata,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection: write wins, reads share by round robin (rr=0 favours rd0).
module dmem_arb_pick
  import cpu_pkg::*;
(
  input  logic       rd0_req,
  input  logic       rd1_req,
  input  logic       wr_req,
  input  logic       rr,
  output arb_grant_t grant
);
  always_comb begin
    grant = G_NONE;
    if (wr_req)                 grant = G_WR;
    else if (rd0_req && rd1_req) grant = rr ? G_RD1 : G_RD0;
    else if (rd0_req)           grant = G_RD0;
    else if (rd1_req)           grant = G_RD1;
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one strobe/done data-memory port between two operand reads and the writeback write.
// Every access runs IDLE -> ACCESS -> DONE -> GAP so the memory always sees two idle strobe cycles.
module dmem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd0_req,
  input  logic [ADDR_W-1:0]    rd0_adr,
  output logic [DATA_W-1:0]    rd0_data,
  output logic                 rd0_ack,
  input  logic                 rd1_req,
  input  logic [ADDR_W-1:0]    rd1_adr,
  output logic [DATA_W-1:0]    rd1_data,
  output logic                 rd1_ack,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    wr_adr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_ack,
  dmem_port_arbiter_if.master  mem,
  output logic                 busy,
  output logic                 err_timeout
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t      state, state_nxt;
  arb_grant_t      grant, pick;
  logic            rr;
  logic [TW-1:0]   tcnt;
  logic            done_hit, tmo_hit;

  dmem_arb_pick u_pick (
    .rd0_req (rd0_req),
    .rd1_req (rd1_req),
    .wr_req  (wr_req),
    .rr      (rr),
    .grant   (pick)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done_hit  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE:   if (pick != G_NONE) state_nxt = ACCESS;
      ACCESS: begin
        if (mem.mem_done) begin
          done_hit  = 1'b1;
          state_nxt = DONE;
        end else if (TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= G_NONE;
      rr            <= 1'b0;
      tcnt          <= '0;
      mem.mem_in    <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_adr   <= '0;
      mem.mem_adr_w <= '0;
      mem.mem_wdata <= '0;
      rd0_data      <= '0;
      rd1_data      <= '0;
      rd0_ack       <= 1'b0;
      rd1_ack       <= 1'b0;
      wr_ack        <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd0_ack     <= 1'b0;
      rd1_ack     <= 1'b0;
      wr_ack      <= 1'b0;
      err_timeout <= 1'b0;
      tcnt        <= (state == ACCESS && state_nxt == ACCESS) ? tcnt + 1'b1 : '0;

      if (state == IDLE && pick != G_NONE) begin
        grant      <= pick;
        mem.mem_in <= (pick != G_WR);
        mem.mem_we <= (pick == G_WR);
        if (pick == G_WR) begin
          mem.mem_adr_w <= wr_adr;
          mem.mem_wdata <= wr_data;
        end else begin
          mem.mem_adr <= (pick == G_RD0) ? rd0_adr : rd1_adr;
        end
        // Point at the read port that did not just win; writes leave it alone.
        if (pick == G_RD0)      rr <= 1'b1;
        else if (pick == G_RD1) rr <= 1'b0;
      end

      if (done_hit || tmo_hit) begin
        mem.mem_in  <= 1'b0;
        mem.mem_we  <= 1'b0;
        rd0_ack     <= (grant == G_RD0);
        rd1_ack     <= (grant == G_RD1);
        wr_ack      <= (grant == G_WR);
        err_timeout <= tmo_hit;
        if (done_hit && grant == G_RD0) rd0_data <= mem.mem_rdata;
        if (done_hit && grant == G_RD1) rd1_data <= mem.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: pick-table vectors, transaction table and multi-cycle sequences.
module tb_dmem_port_arbiter;
  import cpu_pkg::*;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd0_req = 0, rd1_req = 0, wr_req = 0;
  logic [AW-1:0] rd0_adr = '0, rd1_adr = '0, wr_adr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd0_data, rd1_data;
  logic          rd0_ack, rd1_ack, wr_ack, busy, err_timeout;

  logic       p_rd0 = 0, p_rd1 = 0, p_wr = 0, p_rr = 0;
  arb_grant_t p_g;

  int n_vec = 0;
  int n_err = 0;
  int ack_log[$];

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd0_req(rd0_req), .rd0_adr(rd0_adr), .rd0_data(rd0_data), .rd0_ack(rd0_ack),
    .rd1_req(rd1_req), .rd1_adr(rd1_adr), .rd1_data(rd1_data), .rd1_ack(rd1_ack),
    .wr_req(wr_req), .wr_adr(wr_adr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem(mif), .busy(busy), .err_timeout(err_timeout)
  );

  dmem_arb_pick u_pick_chk (
    .rd0_req(p_rd0), .rd1_req(p_rd1), .wr_req(p_wr), .rr(p_rr), .grant(p_g)
  );

  // Memory model: answers one cycle after it sees a strobe; stall withholds done.
  logic          stall = 1'b0;
  logic          m_done = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] mem [16];
  logic [15:0]   wrt = '0;
  assign mif.mem_done  = m_done;
  assign mif.mem_rdata = m_rdata;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return (a == 4'd3) ? 16'hA5A5 : {12'hC00, a};
  endfunction

  always @(posedge clk) begin
    if ((mif.mem_in || mif.mem_we) && !m_done && !stall) begin
      m_done <= 1'b1;
      if (mif.mem_we) begin
        mem[mif.mem_adr_w] <= mif.mem_wdata;
        wrt[mif.mem_adr_w] <= 1'b1;
      end else begin
        m_rdata <= wrt[mif.mem_adr] ? mem[mif.mem_adr] : dflt(mif.mem_adr);
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic ack_of(input int p);
    case (p)
      0:       return rd0_ack;
      1:       return rd1_ack;
      default: return wr_ack;
    endcase
  endfunction

  // Ack order packed one nibble per ack: rd0=1, rd1=2, wr=3.
  function automatic logic [31:0] log_code();
    logic [31:0] c = '0;
    foreach (ack_log[i]) c = (c << 4) | 32'(ack_log[i] + 1);
    return c;
  endfunction

  task automatic xfer(input int p, input logic [AW-1:0] adr, input logic [DW-1:0] wd, output bit ok);
    case (p)
      0:       begin rd0_adr = adr; rd0_req = 1'b1; end
      1:       begin rd1_adr = adr; rd1_req = 1'b1; end
      default: begin wr_adr = adr; wr_data = wd; wr_req = 1'b1; end
    endcase
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = ack_of(p);
    end
    case (p)
      0:       rd0_req = 1'b0;
      1:       rd1_req = 1'b0;
      default: wr_req = 1'b0;
    endcase
  endtask

  task automatic settle();
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ctl"}, 64'({mif.mem_in, mif.mem_we, mif.mem_adr, mif.mem_adr_w,
                             rd0_ack, rd1_ack, wr_ack, busy, err_timeout}), 64'h0);
    check({nm, "_data"}, 64'({rd0_data, rd1_data, mif.mem_wdata}), 64'h0);
  endtask

  // Protocol monitor: ack width, strobe exclusivity, two idle cycles between strobes.
  initial begin
    int  low_run = 0;
    bit  prev_str = 0, seen_op = 0;
    logic pa0 = 0, pa1 = 0, paw = 0;
    forever begin
      @(negedge clk);
      if (rd0_ack) begin ack_log.push_back(0); check("rd0_ack_width", 64'(pa0), 64'h0); end
      if (rd1_ack) begin ack_log.push_back(1); check("rd1_ack_width", 64'(pa1), 64'h0); end
      if (wr_ack)  begin ack_log.push_back(2); check("wr_ack_width",  64'(paw), 64'h0); end
      if (err_timeout) check("err_with_ack", 64'(rd0_ack | rd1_ack | wr_ack), 64'h1);
      if (mif.mem_in || mif.mem_we) begin
        check("strobe_overlap", 64'(mif.mem_in & mif.mem_we), 64'h0);
        if (!prev_str && seen_op) check("strobe_gap", 64'(low_run >= 2), 64'h1);
        seen_op = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_str = mif.mem_in | mif.mem_we;
      pa0 = rd0_ack; pa1 = rd1_ack; paw = wr_ack;
    end
  end

  typedef struct { logic wr, r0, r1, rr; arb_grant_t g; } pv_t;
  typedef struct { int p; logic [AW-1:0] adr; logic [DW-1:0] wd; logic [DW-1:0] exp; } xv_t;

  initial begin
    pv_t pt[16];
    xv_t xt[8];
    bit  ok, ok0, ok1, okw;
    int  c, hi, wa;

    pt[0]  = '{0,0,0,0,G_NONE}; pt[1]  = '{0,0,0,1,G_NONE};
    pt[2]  = '{0,0,1,0,G_RD1};  pt[3]  = '{0,0,1,1,G_RD1};
    pt[4]  = '{0,1,0,0,G_RD0};  pt[5]  = '{0,1,0,1,G_RD0};
    pt[6]  = '{0,1,1,0,G_RD0};  pt[7]  = '{0,1,1,1,G_RD1};
    pt[8]  = '{1,0,0,0,G_WR};   pt[9]  = '{1,0,0,1,G_WR};
    pt[10] = '{1,0,1,0,G_WR};   pt[11] = '{1,0,1,1,G_WR};
    pt[12] = '{1,1,0,0,G_WR};   pt[13] = '{1,1,0,1,G_WR};
    pt[14] = '{1,1,1,0,G_WR};   pt[15] = '{1,1,1,1,G_WR};

    xt[0] = '{2, 4'd8,  16'hBEEF, 16'h0000};
    xt[1] = '{0, 4'd8,  16'h0000, 16'hBEEF};
    xt[2] = '{1, 4'd8,  16'h0000, 16'hBEEF};
    xt[3] = '{2, 4'd8,  16'h0001, 16'h0000};
    xt[4] = '{1, 4'd8,  16'h0000, 16'h0001};
    xt[5] = '{0, 4'd15, 16'h0000, 16'hC00F};
    xt[6] = '{2, 4'd0,  16'hFFFF, 16'h0000};
    xt[7] = '{0, 4'd0,  16'h0000, 16'hFFFF};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");

    for (int i = 0; i < 16; i++) begin
      {p_wr, p_rd0, p_rd1, p_rr} = {pt[i].wr, pt[i].r0, pt[i].r1, pt[i].rr};
      #1 check($sformatf("pick%0d", i), 64'(p_g), 64'(pt[i].g));
    end

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Three-way contention straight out of reset.
    ack_log.delete();
    fork
      xfer(2, 4'd2, 16'h1234, okw);
      xfer(0, 4'd2, 16'h0000, ok0);
      xfer(1, 4'd7, 16'h0000, ok1);
    join
    @(negedge clk);
    check("order_3way", 64'(log_code()), 64'h312);
    check("raw_rd0_data", 64'(rd0_data), 64'h1234);
    check("rd1_data_7", 64'(rd1_data), 64'hC007);
    settle();

    // Single read, hand-timed.
    ack_log.delete();
    rd0_adr = 4'd3; rd0_req = 1'b1;
    @(negedge clk);
    check("t1_strobe", 64'({mif.mem_in, mif.mem_we, mif.mem_adr, busy}), 64'({1'b1, 1'b0, 4'd3, 1'b1}));
    c = 1;
    while (!rd0_ack && c < 50) begin @(negedge clk); c++; end
    rd0_req = 1'b0;
    check("t1_ack_cycle", 64'(c), 64'd3);
    check("t1_rd0_data", 64'(rd0_data), 64'hA5A5);
    @(negedge clk);
    check("t1_gap", 64'({rd0_ack, busy}), 64'b01);
    @(negedge clk);
    check("t1_idle", 64'({busy, rd0_data}), 64'({1'b0, 16'hA5A5}));
    settle();

    // Both reads held for six accesses: rd0 won last, so rd1 leads.
    ack_log.delete();
    fork
      begin for (int i = 0; i < 3; i++) xfer(0, 4'd3, 16'h0, ok0); end
      begin for (int j = 0; j < 3; j++) xfer(1, 4'd4, 16'h0, ok1); end
    join
    @(negedge clk);
    check("rr_alternate", 64'(log_code()), 64'h212121);
    check("rr_rd1_data", 64'(rd1_data), 64'hC004);
    settle();

    // Read of an address with a write pending.
    ack_log.delete();
    fork
      xfer(2, 4'd5, 16'h00FF, okw);
      xfer(0, 4'd5, 16'h0000, ok0);
    join
    @(negedge clk);
    check("raw_order", 64'(log_code()), 64'h31);
    check("raw_data", 64'(rd0_data), 64'h00FF);
    settle();

    // Timeout on rd1.
    stall = 1'b1;
    rd1_adr = 4'd9; rd1_req = 1'b1;
    c = 0; hi = 0;
    while (!rd1_ack && c < 100) begin
      @(negedge clk);
      c++;
      if (mif.mem_in) hi++;
    end
    check("tmo_ack_seen", 64'(rd1_ack), 64'h1);
    check("tmo_access_cycles", 64'(hi), 64'd15);
    check("tmo_err_pulse", 64'(err_timeout), 64'h1);
    check("tmo_rd1_kept", 64'(rd1_data), 64'hC004);
    rd1_req = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("tmo_err_drop", 64'(err_timeout), 64'h0);
    settle();
    xfer(1, 4'd9, 16'h0, ok1);
    check("tmo_next_ok", 64'(ok1), 64'h1);
    check("tmo_next_data", 64'({err_timeout, rd1_data}), 64'({1'b0, 16'hC009}));

    for (int i = 0; i < 8; i++) begin
      settle();
      xfer(xt[i].p, xt[i].adr, xt[i].wd, ok);
      check($sformatf("tbl%0d_ack", i), 64'(ok), 64'h1);
      if (xt[i].p == 0) check($sformatf("tbl%0d_rd0", i), 64'(rd0_data), 64'(xt[i].exp));
      if (xt[i].p == 1) check($sformatf("tbl%0d_rd1", i), 64'(rd1_data), 64'(xt[i].exp));
    end
    settle();

    // Reset during a stalled write.
    stall = 1'b1;
    wr_adr = 4'd1; wr_data = 16'h5555; wr_req = 1'b1;
    c = 0;
    while (!mif.mem_we && c < 20) begin @(negedge clk); c++; end
    check("rst_we_seen", 64'(mif.mem_we), 64'h1);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    wr_req = 1'b0;
    wa = 0;
    repeat (3) begin @(negedge clk); if (wr_ack) wa++; end
    check("rst_no_wr_ack", 64'(wa), 64'h0);
    rst_n = 1'b1; stall = 1'b0;
    ack_log.delete();
    fork
      xfer(0, 4'd3, 16'h0, ok0);
      xfer(1, 4'd4, 16'h0, ok1);
    join
    @(negedge clk);
    check("rst_rr_rd0_first", 64'(log_code()), 64'h12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
